// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding, address field layout and refresh default for the SDRAM arbiter.
package sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} arb_state_e;
  localparam int COL_W = 9;
  localparam int ROW_W = 13;
  localparam int BANK_W = 2;
  localparam int COL_OFF = 0;
  localparam int ROW_OFF = COL_OFF + COL_W;
  localparam int BANK_OFF = ROW_OFF + ROW_W;
  localparam int REFRESH_CYCLES_DEF = 1115;
endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: free-running refresh down-counter with a sticky pending flag.
// SDRAM_ARB_GRANT_CNT_EN adds refresh_drop, high when an expiry is lost to an already-pending refresh.
module sdram_refresh_timer
  import sdram_arb_pkg::*;
#(
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
  input  logic ck143,
  input  logic reset,
  input  logic refresh_ack,
  output logic refresh_pending
`ifdef SDRAM_ARB_GRANT_CNT_EN
  ,
  output logic refresh_drop
`endif
);
  localparam int CW = $clog2(REFRESH_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, expire;
  always_comb begin
    expire = cnt_q == '0;
    cnt_d  = expire ? CW'(REFRESH_CYCLES - 1) : cnt_q - 1'b1;
    pend_d = expire | (pend_q & ~refresh_ack);
  end
  always_ff @(posedge ck143) begin
    if (reset) begin
      cnt_q  <= CW'(REFRESH_CYCLES - 1);
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end
  assign refresh_pending = pend_q;
`ifdef SDRAM_ARB_GRANT_CNT_EN
  assign refresh_drop = expire & pend_q & ~refresh_ack;
`endif
endmodule

// File: rtl/sdram_access_arbiter.sv
// sdram_access_arbiter: round-robin sharing of one SDRAM command port with refresh preemption.
// SDRAM_ARB_GRANT_CNT_EN adds per-requester grant counters and a sticky refresh_overrun flag.
module sdram_access_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = BANK_W + ROW_W + COL_W,
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
  input  logic                        ck143,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic                        cmd_refresh,
  output logic                        cmd_write,
  output logic [ADDR_W-1:0]           cmd_addr,
  input  logic                        cmd_done,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
`ifdef SDRAM_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]       grant_count,
  output logic                        refresh_overrun
`endif
);
  localparam int GW = $clog2(NUM_REQ);
  arb_state_e state_q, state_d;
  logic [GW-1:0] rr_q, rr_d, grant_id_q, grant_id_d, pick;
  logic cmd_refresh_q, cmd_refresh_d, cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic refresh_pending, refresh_ack;
  // Scan downward so the nearest valid requester after the pointer wins.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [GW-1:0] p);
    rr_pick = p;
    for (int i = NUM_REQ; i >= 1; i--)
      if (v[(int'(p) + i) % NUM_REQ]) rr_pick = GW'((int'(p) + i) % NUM_REQ);
  endfunction
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    grant_id_d    = grant_id_q;
    cmd_refresh_d = cmd_refresh_q;
    cmd_write_d   = cmd_write_q;
    cmd_addr_d    = cmd_addr_q;
    req_ready     = '0;
    pick          = rr_pick(req_valid, rr_q);
    case (state_q)
      IDLE:
        if (refresh_pending) begin
          cmd_refresh_d = 1'b1;
          state_d       = ISSUE;
        end else if (|req_valid) begin
          cmd_write_d     = req_write[pick];
          cmd_addr_d      = req_addr[int'(pick)*ADDR_W +: ADDR_W];
          grant_id_d      = pick;
          rr_d            = pick;
          req_ready[pick] = ~reset;
          state_d         = ISSUE;
        end
      ISSUE:
        if (cmd_ready) state_d = WAIT_DONE;
      WAIT_DONE:
        if (cmd_done) begin
          state_d       = IDLE;
          cmd_refresh_d = 1'b0;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ck143) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_q          <= GW'(NUM_REQ - 1);
      grant_id_q    <= '0;
      cmd_refresh_q <= 1'b0;
      cmd_write_q   <= 1'b0;
      cmd_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      grant_id_q    <= grant_id_d;
      cmd_refresh_q <= cmd_refresh_d;
      cmd_write_q   <= cmd_write_d;
      cmd_addr_q    <= cmd_addr_d;
    end
  end
  assign refresh_ack = (state_q == ISSUE) & cmd_refresh_q & cmd_ready;
  assign cmd_valid   = state_q == ISSUE;
  assign busy        = state_q != IDLE;
  assign cmd_refresh = cmd_refresh_q;
  assign cmd_write   = cmd_write_q;
  assign cmd_addr    = cmd_addr_q;
  assign grant_id    = grant_id_q;
`ifdef SDRAM_ARB_GRANT_CNT_EN
  logic refresh_drop;
  logic [NUM_REQ*16-1:0] gcnt_q, gcnt_d;
  logic ovr_q, ovr_d;
  sdram_refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_timer (
    .ck143(ck143), .reset(reset), .refresh_ack(refresh_ack),
    .refresh_pending(refresh_pending), .refresh_drop(refresh_drop)
  );
  always_comb begin
    gcnt_d = gcnt_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i] && gcnt_q[i*16 +: 16] != 16'hFFFF) gcnt_d[i*16 +: 16] = gcnt_q[i*16 +: 16] + 16'd1;
    ovr_d = ovr_q | refresh_drop;
  end
  always_ff @(posedge ck143) begin
    if (reset) begin
      gcnt_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      gcnt_q <= gcnt_d;
      ovr_q  <= ovr_d;
    end
  end
  assign grant_count     = gcnt_q;
  assign refresh_overrun = ovr_q;
`else
  sdram_refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_timer (
    .ck143(ck143), .reset(reset), .refresh_ack(refresh_ack), .refresh_pending(refresh_pending)
  );
`endif
endmodule

// File: tb/tb_sdram_access_arbiter.sv
// tb_sdram_access_arbiter: scoreboard bench; each accepted command is matched against the queued expectation.
module tb_sdram_access_arbiter;
  localparam int RC = 64;
  logic ck143 = 1'b0, reset = 1'b1;
  logic [1:0] req_valid = '0, req_write = '0;
  logic [47:0] req_addr = '0;
  logic [1:0] req_ready;
  logic cmd_valid, cmd_ready = 1'b0, cmd_refresh, cmd_write, cmd_done = 1'b0, busy;
  logic [23:0] cmd_addr;
  logic [0:0] grant_id;
`ifdef SDRAM_ARB_GRANT_CNT_EN
  logic [31:0] grant_count;
  logic refresh_overrun;
`endif
  typedef struct packed {logic rf; logic wr; logic [23:0] addr; logic [0:0] id;} exp_t;
  exp_t exp_q[$];
  exp_t e_mon;
  int checks = 0, errors = 0, done_cnt = 0, done_dly = 4;
  int t0, t1, cnt, nn;
  logic pv;

  sdram_access_arbiter #(.NUM_REQ(2), .ADDR_W(24), .REFRESH_CYCLES(RC)) dut (
    .ck143(ck143), .reset(reset), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_ready(req_ready), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_refresh(cmd_refresh),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_done(cmd_done), .grant_id(grant_id), .busy(busy)
`ifdef SDRAM_ARB_GRANT_CNT_EN
    , .grant_count(grant_count), .refresh_overrun(refresh_overrun)
`endif
  );

  always #5 ck143 = ~ck143;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic rf, input logic wr, input logic [23:0] a, input logic [0:0] id);
    exp_q.push_back({rf, wr, a, id});
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; cmd_ready = 1'b0; done_dly = 4;
    repeat (2) @(posedge ck143);
    #1 reset = 1'b0;
  endtask

  task automatic wait_ready(input int id);
    int n = 0;
    do begin @(negedge ck143); n++; end while (!req_ready[id] && n < 300);
    check("wait_ready", req_ready[id], 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge ck143); n++; end while (busy && n < 300);
    check("wait_idle", busy, 0);
  endtask

  // Controller model: pops the scoreboard on each handshake and answers with cmd_done after done_dly cycles.
  initial forever begin
    @(negedge ck143);
    cmd_done = 1'b0;
    if (reset) done_cnt = 0;
    else begin
      if (done_cnt > 0) begin
        done_cnt--;
        cmd_done = done_cnt == 0;
      end
      if (cmd_valid && cmd_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e_mon = exp_q.pop_front();
          check("sb_refresh", cmd_refresh, e_mon.rf);
          if (!e_mon.rf) begin
            check("sb_write", cmd_write, e_mon.wr);
            check("sb_addr", cmd_addr, e_mon.addr);
            check("sb_gid", grant_id, e_mon.id);
          end
        end
        done_cnt = done_dly;
      end
    end
  end

  initial begin
    #500000 $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge ck143);
    check("rst_valid", cmd_valid, 0);
    check("rst_refresh", cmd_refresh, 0);
    check("rst_write", cmd_write, 0);
    check("rst_addr", cmd_addr, 0);
    check("rst_gid", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    // single read request from requester 0
    @(posedge ck143); #1;
    push(0, 0, 24'h012345, 0);
    req_addr[23:0] = 24'h012345; req_write = 2'b00; req_valid = 2'b01;
    @(negedge ck143);
    check("t1_ready", req_ready, 2'b01);
    check("t1_busy0", busy, 0);
    @(posedge ck143); #1 req_valid = 2'b00;
    @(negedge ck143);
    check("t1_valid", cmd_valid, 1);
    check("t1_addr", cmd_addr, 24'h012345);
    check("t1_write", cmd_write, 0);
    check("t1_gid", grant_id, 0);
    check("t1_pulse", req_ready, 0);
    check("t1_busy1", busy, 1);
    @(posedge ck143); #1 cmd_ready = 1'b1;
    wait_idle();
    // both requesters continuously valid: strict alternation
    do_reset();
    req_addr = {24'h1A2B3C, 24'h0F0E0D}; req_write = 2'b01; cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++)
      push(0, (k % 2 == 0), (k % 2 == 1) ? 24'h1A2B3C : 24'h0F0E0D, 1'(k % 2));
    req_valid = 2'b11;
    cnt = 0; nn = 0;
    while (cnt < 4 && nn < 200) begin
      @(negedge ck143); nn++;
      if (|req_ready) begin
        check("t2_grant", req_ready, (cnt % 2 == 1) ? 2'b10 : 2'b01);
        cnt++;
      end
    end
    check("t2_count", cnt, 4);
    @(posedge ck143); #1 req_valid = 2'b00;
    wait_idle();
    // periodic refresh with no requests
    do_reset();
    push(1, 0, 0, 0); push(1, 0, 0, 0);
    cmd_ready = 1'b1; t0 = -1; t1 = -1; pv = 1'b0;
    for (int n = 0; n <= 2*RC + 6; n++) begin
      @(negedge ck143);
      if (cmd_valid && !pv) begin
        if (t0 < 0) t0 = n;
        else if (t1 < 0) t1 = n;
      end
      pv = cmd_valid;
    end
    check("t3_first", t0, RC + 1);
    check("t3_second", t1, 2*RC + 1);
    wait_idle();
    // refresh expires while requester 1 waits for done; refresh must go before requester 0
    do_reset();
    req_addr = {24'h3C3C3C, 24'h5A5A5A}; req_write = 2'b10; cmd_ready = 1'b1; done_dly = 70;
    push(0, 1, 24'h3C3C3C, 1); push(1, 0, 0, 0); push(0, 0, 24'h5A5A5A, 0);
    req_valid = 2'b10;
    wait_ready(1);
    @(posedge ck143); #1 req_valid = 2'b01;
    @(posedge ck143); #1 done_dly = 4;
    wait_ready(0);
    check("t4_refresh_first", exp_q.size(), 1);
    @(posedge ck143); #1 req_valid = 2'b00;
    wait_idle();
    // stalled cmd_ready keeps the command stable; reset in WAIT_DONE restarts at requester 0
    do_reset();
    req_addr = {24'hABCDEF, 24'h00A5A5}; req_write = 2'b10; done_dly = 20;
    push(0, 1, 24'hABCDEF, 1);
    req_valid = 2'b10;
    wait_ready(1);
    @(posedge ck143); #1 req_valid = 2'b00;
    repeat (10) begin
      @(negedge ck143);
      check("t5_hold_valid", cmd_valid, 1);
      check("t5_hold_addr", cmd_addr, 24'hABCDEF);
      check("t5_hold_write", cmd_write, 1);
    end
    @(posedge ck143); #1 cmd_ready = 1'b1;
    @(negedge ck143);
    @(posedge ck143); #1;
    @(negedge ck143);
    check("t5_wait_busy", busy, 1);
    check("t5_wait_valid", cmd_valid, 0);
    @(posedge ck143); #1;
    reset = 1'b1; req_valid = 2'b11; req_write = 2'b10;
    push(0, 0, 24'h00A5A5, 0);
    @(posedge ck143); #1 reset = 1'b0;
    @(negedge ck143);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_valid", cmd_valid, 0);
    check("t5_rst_winner", req_ready, 2'b01);
    @(posedge ck143); #1 req_valid = 2'b00;
    wait_idle();
`ifdef SDRAM_ARB_GRANT_CNT_EN
    do_reset();
    req_addr = {24'h777777, 24'h000000}; req_write = 2'b00; cmd_ready = 1'b1;
    repeat (3) push(0, 0, 24'h777777, 1);
    req_valid = 2'b10;
    cnt = 0; nn = 0;
    while (cnt < 3 && nn < 200) begin
      @(negedge ck143); nn++;
      if (req_ready[1]) cnt++;
    end
    @(posedge ck143); #1 req_valid = 2'b00;
    wait_idle();
    check("gc_req1", grant_count[31:16], 3);
    check("gc_req0", grant_count[15:0], 0);
    @(posedge ck143); #1 cmd_ready = 1'b0;
    push(1, 0, 0, 0);
    nn = 0;
    do begin @(negedge ck143); nn++; end while (!cmd_valid && nn < 300);
    check("ov_refresh_up", cmd_refresh, 1);
    check("ov_clear", refresh_overrun, 0);
    nn = 0;
    do begin @(negedge ck143); nn++; end while (!refresh_overrun && nn < 300);
    check("ov_set", refresh_overrun, 1);
    @(posedge ck143); #1 cmd_ready = 1'b1;
    wait_idle();
    check("ov_sticky", refresh_overrun, 1);
`endif
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_access_arbiter.md
Name: sdram_access_arbiter

Overview:
- Shares the single SDRAM controller command port between NUM_REQ requesters (e.g. frame-buffer reader, image loader) using round-robin arbitration.
- Owns the periodic auto-refresh schedule. A pending refresh always preempts new requests.
- Sits between the pixel and loader logic and the SDRAM controller, in the ck143 domain.
- Only one burst is outstanding at a time.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 24, word address width: {bank[1:0], row[12:0], col[8:0]}.
- REFRESH_CYCLES, 1115, ck143 cycles between refresh requests (7.8 us at 143 MHz).

Ports:
- ck143  in  1  system/SDRAM clock; all logic is on posedge.
- reset  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester burst request.
- req_write  in  NUM_REQ  1 = write burst, 0 = read burst.
- req_addr  in  NUM_REQ*ADDR_W  packed start addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- cmd_valid  out  1  command presented to the SDRAM controller.
- cmd_ready  in  1  controller accepts the command.
- cmd_refresh  out  1  presented command is an auto-refresh.
- cmd_write  out  1  latched write flag.
- cmd_addr  out  ADDR_W  latched start address.
- cmd_done  in  1  one-cycle pulse when the controller finishes the burst or refresh.
- grant_id  out  $clog2(NUM_REQ)  owner of the current or last grant.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; RR pointer = NUM_REQ-1, so requester 0 wins first; refresh counter = REFRESH_CYCLES-1; refresh_pending = 0.
- Refresh timer:
  - Decrements every cycle regardless of state.
  - At 0 it reloads REFRESH_CYCLES-1 and sets refresh_pending (sticky).
  - refresh_pending clears when the refresh command handshakes.
  - If the timer expires while refresh_pending is already 1, the extra refresh is dropped; the pending flag stays 1.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - If refresh_pending: load cmd_refresh=1, go to ISSUE. No req_ready pulse; requests wait.
  - Else if any req_valid: select the first requester after the RR pointer, wrapping modulo NUM_REQ.
    - Latch its write flag and address; set grant_id; pulse its req_ready for that same cycle; update the RR pointer to the winner; go to ISSUE.
  - Else stay in IDLE.
- Acceptance latency: cmd_valid rises the cycle after req_ready.
- ISSUE:
  - cmd_valid=1, with cmd_* held stable until cmd_ready.
  - On cmd_valid & cmd_ready: drop cmd_valid next cycle, go to WAIT_DONE.
  - A refresh timer expiry during ISSUE only sets the pending flag; the in-flight command is unchanged.
- WAIT_DONE:
  - Wait for cmd_done, then go to IDLE and clear cmd_refresh.
  - A new grant is possible in the cycle after IDLE is entered; minimum turnaround is done → IDLE → ISSUE.
- cmd_done outside WAIT_DONE is ignored.
- Requester obligations: req_valid/req_write/req_addr must be held until req_ready. A requester that deasserts early simply loses its turn; no error is raised.
- Reset asserted mid-operation: immediate return to reset values on the next posedge. Any in-flight command is abandoned; the controller is reset by the same signal.

Optional Feature:
- Macro SDRAM_ARB_GRANT_CNT_EN.
- Defined:
  - Adds output grant_count, NUM_REQ*16 bits.
  - Holds a per-requester count of accepted requests, saturating at 16'hFFFF and cleared by reset.
  - Adds output refresh_overrun: sticky, set when a refresh expiry is dropped.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Package sdram_arb_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT_DONE);
  - the bank/row/col field widths and offsets;
  - the default REFRESH_CYCLES constant.
- Sub-module sdram_refresh_timer: the down-counter, reload, and pending flag with set/clear. Ports: ck143, reset, refresh_ack, refresh_pending.
- The RR picker stays inline as a function.

Test Plan:
- Reset, then req_valid=2'b01, addr 0x012345, write=0 → req_ready[0] pulses; next cycle cmd_valid=1, cmd_addr=0x012345, cmd_write=0, grant_id=0.
- Both requesters hold valid continuously, cmd_ready=1, cmd_done 4 cycles after each handshake → grants alternate 0,1,0,1; no back-to-back repeat.
- REFRESH_CYCLES=20 with no requests → cmd_refresh=1 and cmd_valid at cycle 20 after reset; again 20 cycles later.
- Refresh expires while requester 1 is in WAIT_DONE with requester 0 valid → after cmd_done the refresh issues first, then requester 0 is granted.
- cmd_ready held low for 10 cycles → cmd_addr/cmd_write stay stable; reset pulse in WAIT_DONE → cmd_valid=0, busy=0, and requester 0 wins next.
- With SDRAM_ARB_GRANT_CNT_EN defined, 3 grants to requester 1 → grant_count[31:16]=3; stall cmd_ready across 2 expiries → refresh_overrun=1.
